// File: rtl/distance_scan_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// distance_scan_sequencer
//
// Purpose:
//   Scans the banked distance memory through its two read ports. Each issue
//   cycle reads two consecutive entries (A = p, B = p+1). The block tracks the
//   minimum distance and the index where it first occurs. When
//   DIST_SCAN_SUM_EN is defined, it also accumulates the sum of all scanned
//   distances.
//
// Optional feature macro: DIST_SCAN_SUM_EN (adds dist_sum port + accumulator)
//
// Parameters:
//   DIST_W   width of the distance field, bits [DIST_W-1:0] of each read word
//   MEM_LAT  cycles from address/chip-select issue to valid read data (1..3)
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-low reset
//   start       one-cycle scan request, honoured only when idle
//   count       entries to scan (0..64, larger values clamp to 64)
//   busy        scan in progress (through the done cycle)
//   done        one-cycle completion pulse; results are held afterwards
//   mem_a_addr  port A entry address
//   mem_b_addr  port B entry address
//   mem_csa     port A chip select
//   mem_csb     port B chip select
//   mem_doa     port A read data
//   mem_dob     port B read data
//   min_dist    smallest distance found
//   min_idx     index of min_dist (lowest index on ties)
//   dist_sum    sum of scanned distances (DIST_SCAN_SUM_EN only)
// -----------------------------------------------------------------------------
module distance_scan_sequencer #(
    parameter int DIST_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [6:0]        count,
    output logic              busy,
    output logic              done,
    output logic [5:0]        mem_a_addr,
    output logic [5:0]        mem_b_addr,
    output logic              mem_csa,
    output logic              mem_csb,
    input  logic [63:0]       mem_doa,
    input  logic [63:0]       mem_dob,
    output logic [DIST_W-1:0] min_dist,
    output logic [5:0]        min_idx
`ifdef DIST_SCAN_SUM_EN
    ,
    output logic [DIST_W+5:0] dist_sum
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

    state_t      state_reg, state_next;
    logic [6:0]  ptr_reg, ptr_next;
    logic [6:0]  count_reg, count_next;
    logic [1:0]  drain_reg, drain_next;
    logic        accept;

    // Pointer arithmetic is 7 bits wide, so p+1 = 64 stays distinct from 0.
    logic [6:0]  count_clamped;
    logic [6:0]  ptr_plus1;
    logic [6:0]  ptr_plus2;

    assign count_clamped = (count > 7'd64) ? 7'd64 : count;
    assign ptr_plus1     = ptr_reg + 7'd1;
    assign ptr_plus2     = ptr_reg + 7'd2;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            ptr_reg   <= 7'd0;
            count_reg <= 7'd0;
            drain_reg <= 2'd0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            count_reg <= count_next;
            drain_reg <= drain_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        count_next = count_reg;
        drain_next = drain_reg;
        accept     = 1'b0;
        done       = 1'b0;
        mem_csa    = 1'b0;
        mem_csb    = 1'b0;
        mem_a_addr = 6'd0;
        mem_b_addr = 6'd0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    count_next = count_clamped;
                    ptr_next   = 7'd0;
                    state_next = (count_clamped == 7'd0) ? FINISH : ISSUE;
                end
            end
            ISSUE: begin
                mem_csa    = 1'b1;
                mem_a_addr = ptr_reg[5:0];
                // Odd counts leave the final B slot empty.
                if (ptr_plus1 < count_reg) begin
                    mem_csb    = 1'b1;
                    mem_b_addr = ptr_plus1[5:0];
                end
                ptr_next = ptr_plus2;
                if (ptr_plus2 >= count_reg) begin
                    state_next = DRAIN;
                    drain_next = 2'(MEM_LAT - 1);
                end
            end
            DRAIN: begin
                // The last read returns in the final DRAIN cycle.
                if (drain_reg == 2'd0) begin
                    state_next = FINISH;
                end else begin
                    drain_next = drain_reg - 2'd1;
                end
            end
            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state_reg != IDLE);

    // ------------------------------------------------- read-valid pipeline
    // Each stage carries a valid flag and the entry index for each port.
    // The last stage lines up with the returning DOA/DOB data.
    genvar gi;
    generate
        for (gi = 0; gi < MEM_LAT; gi++) begin : g_pipe
            logic       a_vld_reg, b_vld_reg;
            logic [5:0] a_idx_reg, b_idx_reg;
            logic       a_vld_in, b_vld_in;
            logic [5:0] a_idx_in, b_idx_in;

            if (gi == 0) begin : g_head
                assign a_vld_in = mem_csa;
                assign b_vld_in = mem_csb;
                assign a_idx_in = mem_a_addr;
                assign b_idx_in = mem_b_addr;
            end else begin : g_tail
                assign a_vld_in = g_pipe[gi-1].a_vld_reg;
                assign b_vld_in = g_pipe[gi-1].b_vld_reg;
                assign a_idx_in = g_pipe[gi-1].a_idx_reg;
                assign b_idx_in = g_pipe[gi-1].b_idx_reg;
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    a_vld_reg <= 1'b0;
                    b_vld_reg <= 1'b0;
                    a_idx_reg <= 6'd0;
                    b_idx_reg <= 6'd0;
                end else begin
                    a_vld_reg <= a_vld_in;
                    b_vld_reg <= b_vld_in;
                    a_idx_reg <= a_idx_in;
                    b_idx_reg <= b_idx_in;
                end
            end
        end
    endgenerate

    logic              a_ok, b_ok;
    logic [5:0]        a_idx, b_idx;
    logic [DIST_W-1:0] a_dist, b_dist;

    assign a_ok   = g_pipe[MEM_LAT-1].a_vld_reg;
    assign b_ok   = g_pipe[MEM_LAT-1].b_vld_reg;
    assign a_idx  = g_pipe[MEM_LAT-1].a_idx_reg;
    assign b_idx  = g_pipe[MEM_LAT-1].b_idx_reg;
    assign a_dist = mem_doa[DIST_W-1:0];
    assign b_dist = mem_dob[DIST_W-1:0];

    // Only the distance field is meaningful; the rest of the word is ignored.
    logic unused_hi;
    assign unused_hi = ^{mem_doa[63:DIST_W], mem_dob[63:DIST_W]};

    // ---------------------------------------------------------- min search
    logic [DIST_W-1:0] min_dist_reg, min_dist_next;
    logic [5:0]        min_idx_reg, min_idx_next;

    // A before B with strict less-than: A holds the lower index of the pair,
    // so ties always resolve to the lowest index.
    always_comb begin
        min_dist_next = min_dist_reg;
        min_idx_next  = min_idx_reg;
        if (a_ok && (a_dist < min_dist_next)) begin
            min_dist_next = a_dist;
            min_idx_next  = a_idx;
        end
        if (b_ok && (b_dist < min_dist_next)) begin
            min_dist_next = b_dist;
            min_idx_next  = b_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || accept) begin
            min_dist_reg <= '1;
            min_idx_reg  <= 6'd0;
        end else begin
            min_dist_reg <= min_dist_next;
            min_idx_reg  <= min_idx_next;
        end
    end

    assign min_dist = min_dist_reg;
    assign min_idx  = min_idx_reg;

`ifdef DIST_SCAN_SUM_EN
    // ---------------------------------------------------------- summation
    // Six extra bits hold 64 full-scale distances without wrapping.
    localparam int SUM_W = DIST_W + 6;

    logic [SUM_W-1:0] sum_reg;
    logic [SUM_W-1:0] a_term, b_term;

    assign a_term = a_ok ? {6'd0, a_dist} : '0;
    assign b_term = b_ok ? {6'd0, b_dist} : '0;

    always_ff @(posedge clk) begin
        if (!reset || accept) begin
            sum_reg <= '0;
        end else begin
            sum_reg <= sum_reg + a_term + b_term;
        end
    end

    assign dist_sum = sum_reg;
`endif

endmodule

// File: tb/tb_distance_scan_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_distance_scan_sequencer
//
// Directed and randomized scans of distance_scan_sequencer against a
// behavioural memory and a reference model. Expectations are computed from
// the scan rules (min with lowest-index tie-break, sum, issue schedule,
// done cycle = ceil(count/2) + MEM_LAT + 1).
// -----------------------------------------------------------------------------
module tb_distance_scan_sequencer;

    localparam int DIST_W  = 32;
    localparam int MEM_LAT = 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [6:0]        count;
    logic              busy, done;
    logic [5:0]        mem_a_addr, mem_b_addr;
    logic              mem_csa, mem_csb;
    logic [63:0]       mem_doa, mem_dob;
    logic [DIST_W-1:0] min_dist;
    logic [5:0]        min_idx;
`ifdef DIST_SCAN_SUM_EN
    logic [DIST_W+5:0] dist_sum;
`endif

    always #5 clk = ~clk;

    distance_scan_sequencer #(.DIST_W(DIST_W), .MEM_LAT(MEM_LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .mem_a_addr (mem_a_addr),
        .mem_b_addr (mem_b_addr),
        .mem_csa    (mem_csa),
        .mem_csb    (mem_csb),
        .mem_doa    (mem_doa),
        .mem_dob    (mem_dob),
        .min_dist   (min_dist),
        .min_idx    (min_idx)
`ifdef DIST_SCAN_SUM_EN
        ,
        .dist_sum   (dist_sum)
`endif
    );

    // ------------------------------------------------------ memory model
    bit [DIST_W-1:0] ent [64];
    logic [63:0] pa [MEM_LAT];
    logic [63:0] pb [MEM_LAT];

    // Unselected reads return garbage, and the upper word bits are always random.
    function automatic logic [63:0] rd_word(input logic en, input logic [5:0] a);
        logic [63:0] w;
        w = {$urandom, $urandom};
        if (en) w[DIST_W-1:0] = ent[a];
        return w;
    endfunction

    always @(posedge clk) begin
        pa[0] <= rd_word(mem_csa, mem_a_addr);
        pb[0] <= rd_word(mem_csb, mem_b_addr);
        for (int i = 1; i < MEM_LAT; i++) begin
            pa[i] <= pa[i-1];
            pb[i] <= pb[i-1];
        end
    end
    assign mem_doa = pa[MEM_LAT-1];
    assign mem_dob = pb[MEM_LAT-1];

    // ------------------------------------------------------------ checks
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: min with lowest-index tie-break, and sum over the clamped count.
    task automatic model(input int c, output logic [DIST_W-1:0] md,
                         output logic [5:0] mi, output logic [DIST_W+5:0] s);
        int cc;
        cc = (c > 64) ? 64 : c;
        md = '1;
        mi = 6'd0;
        s  = '0;
        for (int i = 0; i < cc; i++) begin
            s = s + (DIST_W+6)'(ent[i]);
            if (ent[i] < md) begin
                md = ent[i];
                mi = 6'(i);
            end
        end
    endtask

    task automatic check_results(input string tag, input logic [DIST_W-1:0] md,
                                 input logic [5:0] mi, input logic [DIST_W+5:0] s);
        check({tag, ".min_dist"}, 64'(min_dist), 64'(md));
        check({tag, ".min_idx"},  64'(min_idx),  64'(mi));
`ifdef DIST_SCAN_SUM_EN
        check({tag, ".dist_sum"}, 64'(dist_sum), 64'(s));
`else
        if (s != s) $display("unreachable");
`endif
    endtask

    // One complete scan: start in IDLE, then check every cycle through two
    // cycles past the expected done. With spam set, start is re-asserted in
    // cycles 2..10, and count is randomized throughout the scan.
    task automatic run_scan(input string name, input int c, input bit spam);
        int cc, p, exp_done, done_at;
        logic [DIST_W-1:0] md;
        logic [5:0]        mi;
        logic [DIST_W+5:0] s;
        bit iss, csb_e;
        cc       = (c > 64) ? 64 : c;
        p        = (cc + 1) / 2;
        exp_done = (cc == 0) ? 1 : p + MEM_LAT + 1;
        done_at  = -1;
        model(c, md, mi, s);

        @(negedge clk);
        start = 1'b1;
        count = 7'(c);
        for (int cyc = 1; cyc <= exp_done + 2; cyc++) begin
            @(negedge clk);
            start = spam && (cyc >= 2) && (cyc <= 10);
            count = 7'($urandom);
            iss   = (cyc <= p);
            csb_e = iss && ((2 * cyc - 1) < cc);
            if (done === 1'b1 && done_at < 0) done_at = cyc;
            check($sformatf("%s.c%0d.busy", name, cyc), 64'(busy), 64'(cyc <= exp_done));
            check($sformatf("%s.c%0d.done", name, cyc), 64'(done), 64'(cyc == exp_done));
            check($sformatf("%s.c%0d.csa", name, cyc), 64'(mem_csa), 64'(iss));
            check($sformatf("%s.c%0d.a_addr", name, cyc), 64'(mem_a_addr),
                  iss ? 64'(2 * (cyc - 1)) : 64'd0);
            check($sformatf("%s.c%0d.csb", name, cyc), 64'(mem_csb), 64'(csb_e));
            check($sformatf("%s.c%0d.b_addr", name, cyc), 64'(mem_b_addr),
                  csb_e ? 64'(2 * cyc - 1) : 64'd0);
            if (cyc == exp_done) check_results({name, ".at_done"}, md, mi, s);
        end
        start = 1'b0;
        // Results are held after done.
        check_results({name, ".held"}, md, mi, s);
        $display("scan %s count=%0d min_dist=%0d min_idx=%0d done_cycle=%0d (expected %0d)",
                 name, c, min_dist, min_idx, done_at, exp_done);
    endtask

    // -------------------------------------------------------- stimulus
    initial begin
        reset = 1'b0;
        start = 1'b0;
        count = 7'd0;
        repeat (3) @(negedge clk);
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        check("reset.csa", 64'(mem_csa), 64'd0);
        check("reset.csb", 64'(mem_csb), 64'd0);
        check("reset.a_addr", 64'(mem_a_addr), 64'd0);
        check("reset.b_addr", 64'(mem_b_addr), 64'd0);
        check_results("reset", '1, 6'd0, '0);
        reset = 1'b1;
        @(negedge clk);

        // Full scan with descending distances: minimum is at the last entry.
        for (int i = 0; i < 64; i++) ent[i] = DIST_W'(1000 - i);
        run_scan("desc64", 64, 1'b0);

        // Odd count leaves the last B slot empty; entries past count are junk.
        for (int i = 0; i < 64; i++) ent[i] = DIST_W'($urandom_range(0, 2));
        ent[0] = 40; ent[1] = 7; ent[2] = 19; ent[3] = 7; ent[4] = 3;
        run_scan("odd5", 5, 1'b0);

        // Ties resolve to the lower index.
        ent[0] = 9; ent[1] = 2; ent[2] = 2; ent[3] = 5;
        run_scan("tie4", 4, 1'b0);

        // The tie spans a port-A/port-B pair boundary.
        ent[0] = 9; ent[1] = 4; ent[2] = 4; ent[3] = 4; ent[4] = 8;
        run_scan("tie5", 5, 1'b0);

        run_scan("zero", 0, 1'b0);

        for (int i = 0; i < 64; i++) ent[i] = $urandom;
        run_scan("spam20", 20, 1'b1);

        // Counts above 64 clamp to 64.
        run_scan("clamp127", 127, 1'b0);

        // Full-scale distances never beat the cleared minimum.
        for (int i = 0; i < 64; i++) ent[i] = '1;
        run_scan("allones", 64, 1'b0);

        // Reset in cycle 3 of a full scan.
        for (int i = 0; i < 64; i++) ent[i] = $urandom;
        @(negedge clk);
        start = 1'b1;
        count = 7'd64;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst.busy", 64'(busy), 64'd0);
        check("midrst.done", 64'(done), 64'd0);
        check("midrst.csa", 64'(mem_csa), 64'd0);
        check("midrst.csb", 64'(mem_csb), 64'd0);
        check_results("midrst", '1, 6'd0, '0);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 64; i++) ent[i] = DIST_W'($urandom_range(100, 5000));
        run_scan("after_rst", 64, 1'b0);

        // Randomized scans.
        for (int t = 0; t < 20; t++) begin
            int mode;
            mode = $urandom_range(0, 2);
            for (int i = 0; i < 64; i++) begin
                case (mode)
                    0:       ent[i] = $urandom;
                    1:       ent[i] = DIST_W'($urandom_range(0, 7));
                    default: ent[i] = ($urandom_range(0, 3) == 0) ? DIST_W'($urandom) : '1;
                endcase
            end
            run_scan($sformatf("rand%0d", t), int'($urandom_range(0, 127)), t[0]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/distance_scan_sequencer.md
# distance_scan_sequencer

Sequences a full scan of the banked distance memory through its two read ports (A and B) and reports the minimum distance and the index where it occurs. Sits between the particle-filter control FSM and the distance memory controller. It drives the controller's A/B address and chip-select inputs and consumes the 64-bit DOA/DOB read data. Two entries are read per cycle, one per port, so a 64-entry scan takes 32 issue cycles.

## Interface
- DIST_W, 32: width of the distance field, taken from bits [DIST_W-1:0] of each 64-bit read word.
- MEM_LAT, 1: cycles from address/chip-select issue to valid DOA/DOB data; legal range 1–3.

- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle scan request; sampled only in IDLE.
- count  in  7  number of entries to scan (0–64); values >64 are clamped to 64.
- busy  out  1  high from the cycle after start is accepted until the cycle done is high (inclusive).
- done  out  1  one-cycle pulse; results are valid in that cycle and held until the next accepted start.
- mem_a_addr  out  6  port A entry address (to A_in).
- mem_b_addr  out  6  port B entry address (to B_in).
- mem_csa  out  1  port A chip select (to CSA).
- mem_csb  out  1  port B chip select (to CSB).
- mem_doa  in  64  port A read data.
- mem_dob  in  64  port B read data.
- min_dist  out  DIST_W  smallest distance found.
- min_idx  out  6  entry index of min_dist.
- dist_sum  out  DIST_W+6  sum of all scanned distances; present only with DIST_SCAN_SUM_EN.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, FINISH.
- IDLE:
  - start=1 and count≥1: clear accumulators (min_dist=all ones, min_idx=0, dist_sum=0), set issue pointer p=0, go to ISSUE.
  - start=1 and count=0: go straight to FINISH with the cleared accumulators.
- ISSUE, each cycle:
  - mem_csa=1, mem_a_addr=p.
  - mem_csb=1 only if p+1<count; mem_b_addr=p+1 when enabled, 0 otherwise.
  - p advances by 2. After the cycle where p+2≥count, go to DRAIN.
- Read-valid tracking: a MEM_LAT-deep pipeline carries a valid flag and the address for each port. Returning data is qualified only by its own port's valid bit.
- Compare, per returning pair:
  - Port A is evaluated first, then port B, against the running minimum.
  - Strict less-than is used, so ties keep the lower index.
  - An invalid port B slot is ignored.
- DRAIN: wait until the pipeline is empty (MEM_LAT cycles), then go to FINISH.
- FINISH: done=1 for one cycle, then go to IDLE.
- While busy, mem_csa and mem_csb are 0 outside ISSUE, and addresses are driven to 0.
- start while busy is ignored; no queuing.
- Width rules:
  - Distances are unsigned.
  - dist_sum does not wrap: 64×(2^DIST_W−1) fits in DIST_W+6 bits.
  - Address arithmetic uses 7 bits internally, so p+1=64 never aliases to 0.
- Reset (reset=0), at any time including mid-scan:
  - Next edge forces IDLE and discards in-flight reads.
  - Output reset values: busy=0, done=0, mem_csa=0, mem_csb=0, mem_a_addr=0, mem_b_addr=0, min_dist=all ones, min_idx=0, dist_sum=0.

## Timing
- Start accepted at edge 0 (start=1 in IDLE).
- ISSUE occupies cycles 1..P, where P=ceil(count/2).
- Last data returns in cycle P+MEM_LAT and updates the accumulators at the end of that cycle.
- done is high in cycle P+MEM_LAT+1.
  - count=64, MEM_LAT=1: done in cycle 34.
  - count=0: done in cycle 1.
- A new start is accepted no earlier than the cycle after done; back-to-back scans therefore have one IDLE cycle between them.

## Configuration
- DIST_SCAN_SUM_EN defined:
  - dist_sum port and its accumulator exist.
  - The accumulator adds every valid A and B distance (both in the same cycle when both are valid).
  - It is cleared on accepted start and on reset.
- DIST_SCAN_SUM_EN undefined:
  - dist_sum port and all summation logic are removed.
  - min search, timing and handshake are identical in both builds.

## Test plan
- count=64, entry i holds distance 1000−i, MEM_LAT=1 → done in cycle 34, min_dist=937, min_idx=63, dist_sum=61984.
- count=5, entries {40,7,19,7,3} → the third issue cycle has mem_csb=0; min_dist=3, min_idx=4, dist_sum=76; done in cycle 5.
- Tie: count=4, entries {9,2,2,5} → min_idx=1 (lower index wins); min_dist=2.
- count=0 → done in cycle 1; min_dist=0xFFFFFFFF, min_idx=0, no chip select ever asserted.
- Assert start again in cycles 2–10 of a count=20 scan → ignored; exactly one done, results match a single scan.
- reset=0 in cycle 3 of a count=64 scan → the following cycle shows busy=0, chip selects 0, min_dist=all ones; a fresh start then completes normally with correct results.
